demux_memoria: RTL and testbench

//  Inverse of the 2:1 mux-with-memory: takes one 2-bit word stream plus a lane selector
//  and routes each accepted word into one of two buffered output lanes.

---
 rtl/demux_memoria_pkg.sv | 12 +
 rtl/demux_memoria_fifo_carril.sv | 110 +++++++++++
 rtl/demux_memoria.sv | 96 +++++++++
 tb/tb_demux_memoria.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/demux_memoria_pkg.sv
// Shared definitions for the demux_memoria slice.
// Default widths and depth for the lane FIFOs, and the lane encoding of the selector.
package demux_memoria_pkg;

  localparam int DEF_DATA_W = 2;  // word width
  localparam int DEF_DEPTH  = 2;  // entries per lane FIFO (power of 2, >= 2)
  localparam int DEF_CNT_W  = 4;  // transition counter width

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage : demux_memoria_pkg

// File: rtl/demux_memoria_fifo_carril.sv
// fifo_carril: one output lane of the demux.
// A DEPTH-entry FIFO plus a last-pushed-word register and a wrapping counter of
// 0->1 bit transitions between consecutive pushed words.
// Ports:
//   clk, reset_L  clock, asynchronous active-low reset
//   push, din     write din at the tail (ignored when full)
//   pop           advance the head (ignored when empty)
//   dout, valid   head word (0 when empty), lane not empty
//   full          lane cannot accept a word this cycle
//   count         transition counter, mod 2^CNT_W
module fifo_carril
  import demux_memoria_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Number of bit positions that go 0 -> 1 from prev to cur.
  function automatic logic [CNT_W-1:0] rise_count(input logic [DATA_W-1:0] prev,
                                                   input logic [DATA_W-1:0] cur);
    logic [CNT_W-1:0] sum;
    sum = {CNT_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      sum = sum + CNT_W'(~prev[i] & cur[i]);
    end
    return sum;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] prev_r;
  logic [CNT_W-1:0]  count_r;

  logic              empty_s;
  logic              full_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Pointer compare: same index with differing wrap bit means full.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // No bypass: a full lane refuses the push even if it pops this cycle.
    do_push_s = push & ~full_s;
    do_pop_s  = pop & ~empty_s;
  end

  // Storage array; contents need no reset since valid gates dout.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Previous accepted word and wrapping transition counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev_r  <= {DATA_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (do_push_s) begin
      prev_r  <= din;
      count_r <= count_r + rise_count(prev_r, din);
    end
  end

  // Head word is forced to zero when the lane is empty.
  always_comb begin
    if (empty_s) begin
      dout = {DATA_W{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  assign valid = ~empty_s;
  assign full  = full_s;
  assign count = count_r;

endmodule : fifo_carril

// File: rtl/demux_memoria.sv
// demux_memoria: routes an incoming word stream into one of two buffered lanes.
// Ports:
//   clk, reset_L              clock, asynchronous active-low reset
//   valid_in, selector, data_in   offered word and its destination lane
//   ready_in                  selected lane has room (combinational)
//   data_outN, valid_outN, popN   lane N head, not-empty flag, consumer pop
//   countN                    lane N 0->1 transition counter
//   drop_err                  sticky: a word was offered to a full lane
module demux_memoria
  import demux_memoria_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic              selector,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] data_out0,
  output logic              valid_out0,
  input  logic              pop0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out1,
  input  logic              pop1,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic              drop_err
);

  logic full0_s;
  logic full1_s;
  logic push0_s;
  logic push1_s;
  logic ready_s;
  logic drop_err_r;

  // Selector decode: readiness and push strobe follow the addressed lane only.
  always_comb begin
    push0_s = 1'b0;
    push1_s = 1'b0;
    ready_s = 1'b1;
    case (selector)
      LANE0: begin
        ready_s = ~full0_s;
        push0_s = valid_in & ~full0_s;
      end
      LANE1: begin
        ready_s = ~full1_s;
        push1_s = valid_in & ~full1_s;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      drop_err_r <= 1'b0;
    end else if (valid_in && !ready_s) begin
      drop_err_r <= 1'b1;
    end
  end

  fifo_carril #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_carril0 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push0_s),
    .din     (data_in),
    .pop     (pop0),
    .dout    (data_out0),
    .valid   (valid_out0),
    .full    (full0_s),
    .count   (count0)
  );

  fifo_carril #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_carril1 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push1_s),
    .din     (data_in),
    .pop     (pop1),
    .dout    (data_out1),
    .valid   (valid_out1),
    .full    (full1_s),
    .count   (count1)
  );

  assign ready_in = ready_s;
  assign drop_err = drop_err_r;

endmodule : demux_memoria

// File: tb/tb_demux_memoria.sv
// Self-checking bench for demux_memoria (DATA_W=2, DEPTH=2, CNT_W=4).
// Stimulus records the words it expects each lane to hold; a negedge monitor
// compares lane heads and valid flags against those expectations.
module tb_demux_memoria;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       valid_in;
  logic       selector;
  logic [1:0] data_in;
  logic       ready_in;
  logic [1:0] data_out0;
  logic       valid_out0;
  logic       pop0;
  logic [1:0] data_out1;
  logic       valid_out1;
  logic       pop1;
  logic [3:0] count0;
  logic [3:0] count1;
  logic       drop_err;

  int errors = 0;
  int checks = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  demux_memoria dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .selector   (selector),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .pop0       (pop0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pop1       (pop1),
    .count0     (count0),
    .count1     (count1),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: lane outputs must match the expected lane contents.
  always @(negedge clk) begin
    logic [1:0] e0;
    logic [1:0] e1;
    e0 = (q0.size() != 0) ? q0[0] : 2'b00;
    e1 = (q1.size() != 0) ? q1[0] : 2'b00;
    chk("valid_out0", 8'(valid_out0), 8'(q0.size() != 0));
    chk("data_out0",  8'(data_out0),  8'(e0));
    chk("valid_out1", 8'(valid_out1), 8'(q1.size() != 0));
    chk("data_out1",  8'(data_out1),  8'(e1));
  end

  // One clock of stimulus; acc is the hand-decided acceptance of the offered word.
  task automatic cycle(input logic v, input logic sel, input logic [1:0] d,
                       input logic p0, input logic p1, input logic acc);
    valid_in = v; selector = sel; data_in = d; pop0 = p0; pop1 = p1;
    @(posedge clk); #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    if (acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
  endtask

  initial begin
    // Reset with valid_in held high: nothing may be captured.
    reset_L = 1'b0; valid_in = 1'b1; selector = 1'b0; data_in = 2'b11;
    pop0 = 1'b0; pop1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid_out0", 8'(valid_out0), 8'd0);
    chk("rst_valid_out1", 8'(valid_out1), 8'd0);
    chk("rst_data_out0",  8'(data_out0),  8'd0);
    chk("rst_data_out1",  8'(data_out1),  8'd0);
    chk("rst_count0",     8'(count0),     8'd0);
    chk("rst_count1",     8'(count1),     8'd0);
    chk("rst_drop_err",   8'(drop_err),   8'd0);
    chk("rst_ready_in",   8'(ready_in),   8'd1);
    valid_in = 1'b0;
    reset_L = 1'b1;
    @(posedge clk); #1;

    // Routing: 01 to lane 0, 10 to lane 1.
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("route_count0", 8'(count0), 8'd1);
    chk("route_count1", 8'(count1), 8'd1);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);

    // Fill lane 0: 11 (+1 from 01), 10 (+0); third push refused.
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    selector = 1'b0; #1;
    chk("full0_ready_sel0", 8'(ready_in), 8'd0);
    selector = 1'b1; #1;
    chk("full0_ready_sel1", 8'(ready_in), 8'd1);
    chk("drop_err_before", 8'(drop_err), 8'd0);
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("drop_err_set", 8'(drop_err), 8'd1);
    chk("full0_count0", 8'(count0), 8'd2);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);  // pop on empty lane ignored

    // Lane 1 full: 01 (+1), 11 (+1) -> count1 = 3.
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    chk("full1_count1", 8'(count1), 8'd3);
    // Full lane: push+pop -> pop only.
    cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("full1_ready_after_pop", 8'(ready_in), 8'd1);
    // One entry: push+pop -> occupancy stays 1, 11 -> 10 adds 0.
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    chk("simul_count1", 8'(count1), 8'd3);
    cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);

    // Reset pulse, then counter wrap on lane 0.
    reset_L = 1'b0; q0.delete(); q1.delete();
    @(posedge clk); #1;
    reset_L = 1'b1;
    chk("drop_err_cleared", 8'(drop_err), 8'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
      if (k == 6) chk("wrap_count0_mid", 8'(count0), 8'd14);
    end
    chk("wrap_count0", 8'(count0), 8'd0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Async reset mid-stream with both lanes non-empty.
    cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("pre_areset_count1", 8'(count1), 8'd1);
    #2;
    reset_L = 1'b0; q0.delete(); q1.delete();
    #1;
    chk("areset_valid_out0", 8'(valid_out0), 8'd0);
    chk("areset_valid_out1", 8'(valid_out1), 8'd0);
    chk("areset_data_out0",  8'(data_out0),  8'd0);
    chk("areset_data_out1",  8'(data_out1),  8'd0);
    chk("areset_count1",     8'(count1),     8'd0);
    chk("areset_ready_in",   8'(ready_in),   8'd1);
    @(posedge clk); #1;
    reset_L = 1'b1;
    cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    chk("post_count0", 8'(count0), 8'd2);
    cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux_memoria
